mem_datos_np: RTL and testbench

Parametrised N-port synchronous data memory for the superscalar datapath's MEM stage; one port per issue slot. Successor to the two-port combinational data memory: configurable width, depth, port count and base window; registered reads with valid strobe; defined same-cycle write-conflict and read-during-write rules; out-of-window detection with a saturating error counter.

---
 rtl/mem_datos_pkg.sv | 32 +++
 rtl/mem_datos_np_if.sv | 28 ++
 rtl/mem_datos_dec.sv | 35 +++
 rtl/mem_datos_np.sv | 138 +++++++++++++
 tb/tb_mem_datos_np.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_datos_pkg.sv
// rtl/mem_datos_pkg.sv - shared constants, op encoding and helpers for mem_datos_np
package mem_datos_pkg;

  localparam logic [31:0] MEM_BASE_ADDR    = 32'h1000_0000;
  localparam logic [31:0] MEM_DEFAULT_DATA = 32'h0000_0020;

  localparam logic [31:0] INIT_W0 = 32'h0000_0010;
  localparam logic [31:0] INIT_W1 = 32'h0000_0008;
  localparam logic [31:0] INIT_W2 = 32'h0000_000D;
  localparam logic [31:0] INIT_W3 = 32'h0000_0002;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mem_op_e;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic logic [31:0] init_word(input int w);
    case (w)
      0:       return INIT_W0;
      1:       return INIT_W1;
      2:       return INIT_W2;
      3:       return INIT_W3;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mem_datos_np_if.sv
// rtl/mem_datos_np_if.sv - per-port request/response bundle for mem_datos_np
interface mem_datos_np_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic [N_PORTS-1:0]        Mem_rd;
  logic [N_PORTS-1:0]        Mem_wr;
  logic [N_PORTS*ADDR_W-1:0] Dir_Mem;
  logic [N_PORTS*DATA_W-1:0] Dato_Mem_in;
  logic [N_PORTS*DATA_W-1:0] Dato_Mem_out;
  logic [N_PORTS-1:0]        Dato_valido;
  logic [N_PORTS-1:0]        Fuera_rango;
  logic                      Conflicto;
  logic [7:0]                Cuenta_err;

  modport master (
    output Mem_rd, Mem_wr, Dir_Mem, Dato_Mem_in,
    input  Dato_Mem_out, Dato_valido, Fuera_rango, Conflicto, Cuenta_err
  );

  modport slave (
    input  Mem_rd, Mem_wr, Dir_Mem, Dato_Mem_in,
    output Dato_Mem_out, Dato_valido, Fuera_rango, Conflicto, Cuenta_err
  );

endinterface

// File: rtl/mem_datos_dec.sv
// rtl/mem_datos_dec.sv - per-port address window check and request decode
module mem_datos_dec
  import mem_datos_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter int               DEPTH     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(MEM_BASE_ADDR),
  parameter int               IDX_W     = idx_w(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_n,
  input  logic              wr_n,
  output mem_op_e           op,
  output logic              in_range,
  output logic [IDX_W-1:0]  idx
);

  logic [ADDR_W-1:0] offset;

  // Unsigned wrap makes addresses below the base land far outside the window.
  assign offset   = addr - BASE_ADDR;
  assign in_range = (offset < ADDR_W'(DEPTH));
  assign idx      = offset[IDX_W-1:0];

  // Read takes precedence; a simultaneous write request is dropped.
  always_comb begin
    op = OP_IDLE;
    if (!rd_n) begin
      op = OP_READ;
    end else if (!wr_n) begin
      op = OP_WRITE;
    end
  end

endmodule

// File: rtl/mem_datos_np.sv
// rtl/mem_datos_np.sv - N-port synchronous data memory with forwarding and window checks
module mem_datos_np
  import mem_datos_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                DEPTH        = 16,
  parameter int                N_PORTS      = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(MEM_BASE_ADDR),
  parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(MEM_DEFAULT_DATA)
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_datos_np_if.slave  bus
);

  localparam int IDX_W = idx_w(DEPTH);

  logic [DATA_W-1:0]                 mem [DEPTH];

  mem_op_e                           op [N_PORTS];
  logic [N_PORTS-1:0]                in_rng;
  logic [N_PORTS-1:0][IDX_W-1:0]     idx;
  logic [N_PORTS-1:0][DATA_W-1:0]    wdata;

  logic [N_PORTS-1:0]                rd_en;
  logic [N_PORTS-1:0]                wr_en;
  logic [N_PORTS-1:0]                oor;
  logic                              conflict;
  logic [N_PORTS-1:0][DATA_W-1:0]    rd_data;
  logic [3:0]                        n_oor;
  logic [8:0]                        cnt_sum;

  logic [N_PORTS-1:0][DATA_W-1:0]    dout_q;
  logic [N_PORTS-1:0]                valid_q;
  logic [N_PORTS-1:0]                oor_q;
  logic                              conflict_q;
  logic [7:0]                        cnt_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    mem_datos_dec #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE_ADDR),
      .IDX_W     (IDX_W)
    ) u_dec (
      .addr     (bus.Dir_Mem[p*ADDR_W +: ADDR_W]),
      .rd_n     (bus.Mem_rd[p]),
      .wr_n     (bus.Mem_wr[p]),
      .op       (op[p]),
      .in_range (in_rng[p]),
      .idx      (idx[p])
    );

    assign wdata[p] = bus.Dato_Mem_in[p*DATA_W +: DATA_W];
  end

  always_comb begin
    rd_en = '0;
    wr_en = '0;
    oor   = '0;
    n_oor = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      rd_en[p] = (op[p] == OP_READ);
      wr_en[p] = (op[p] == OP_WRITE) && in_rng[p];
      oor[p]   = (op[p] != OP_IDLE) && !in_rng[p];
      n_oor    = n_oor + 4'(oor[p]);
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      for (int q = p + 1; q < N_PORTS; q++) begin
        if (wr_en[p] && wr_en[q] && (idx[p] == idx[q])) begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Write-first: scanning ascending leaves the highest-numbered writer, matching the merge.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      rd_data[p] = in_rng[p] ? mem[idx[p]] : DEFAULT_DATA;
      for (int q = 0; q < N_PORTS; q++) begin
        if (in_rng[p] && wr_en[q] && (idx[q] == idx[p])) begin
          rd_data[p] = wdata[q];
        end
      end
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + 9'(n_oor);

  // Later non-blocking assignments override earlier ones, so the top port wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= DATA_W'(init_word(w));
      end
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (wr_en[p]) begin
          mem[idx[p]] <= wdata[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      valid_q    <= '0;
      oor_q      <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (rd_en[p]) begin
          dout_q[p] <= rd_data[p];
        end
      end
      valid_q    <= rd_en;
      oor_q      <= oor;
      conflict_q <= conflict;
      cnt_q      <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

  assign bus.Dato_Mem_out = dout_q;
  assign bus.Dato_valido  = valid_q;
  assign bus.Fuera_rango  = oor_q;
  assign bus.Conflicto    = conflict_q;
  assign bus.Cuenta_err   = cnt_q;

endmodule

// File: tb/tb_mem_datos_np.sv
// tb/tb_mem_datos_np.sv - scoreboard bench for mem_datos_np
module tb_mem_datos_np;

  typedef struct {
    logic [31:0] data;
    logic        fr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t expq [2][$];

  mem_datos_np_if #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32)) bus ();

  mem_datos_np #(
    .DATA_W       (32),
    .ADDR_W       (32),
    .DEPTH        (16),
    .N_PORTS      (2),
    .BASE_ADDR    (32'h1000_0000),
    .DEFAULT_DATA (32'h0000_0020)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic drive(input int p, input logic rd_n, input logic wr_n,
                       input logic [31:0] a, input logic [31:0] d);
    bus.Mem_rd[p]           = rd_n;
    bus.Mem_wr[p]           = wr_n;
    bus.Dir_Mem[p*32 +: 32] = a;
    bus.Dato_Mem_in[p*32 +: 32] = d;
  endtask

  task automatic idle_all();
    drive(0, 1'b1, 1'b1, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h0, 32'h0);
  endtask

  task automatic expect_rd(input int p, input logic [31:0] d, input logic fr);
    exp_t e;
    e.data = d;
    e.fr   = fr;
    expq[p].push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: every valid read response is matched against the oldest expectation for that port.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (bus.Dato_valido[p]) begin
          if (expq[p].size() == 0) begin
            chk($sformatf("unexpected_valid_p%0d", p), 32'(bus.Dato_valido[p]), 32'h0);
          end else begin
            exp_t e;
            e = expq[p].pop_front();
            chk($sformatf("rd_data_p%0d", p), bus.Dato_Mem_out[p*32 +: 32], e.data);
            chk($sformatf("rd_fr_p%0d", p), 32'(bus.Fuera_rango[p]), 32'(e.fr));
          end
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_all();
    step();
    step();
    chk("rst_dout0", bus.Dato_Mem_out[31:0], 32'h0);
    chk("rst_dout1", bus.Dato_Mem_out[63:32], 32'h0);
    chk("rst_valid", 32'(bus.Dato_valido), 32'h0);
    chk("rst_fr", 32'(bus.Fuera_rango), 32'h0);
    chk("rst_conf", 32'(bus.Conflicto), 32'h0);
    chk("rst_cnt", 32'(bus.Cuenta_err), 32'h0);
    rst_n = 1'b1;
    step();

    drive(0, 1'b0, 1'b1, 32'h1000_0002, 32'h0);
    expect_rd(0, 32'h0000_000D, 1'b0);
    step();
    chk("cnt_after_first_read", 32'(bus.Cuenta_err), 32'h0);

    drive(0, 1'b1, 1'b0, 32'h1000_0005, 32'hDEAD_BEEF);
    drive(1, 1'b0, 1'b1, 32'h1000_0005, 32'h0);
    expect_rd(1, 32'hDEAD_BEEF, 1'b0);
    step();
    chk("fwd_no_conflict", 32'(bus.Conflicto), 32'h0);
    chk("fwd_no_fr", 32'(bus.Fuera_rango), 32'h0);
    chk("fwd_wr_no_valid0", 32'(bus.Dato_valido[0]), 32'h0);

    drive(0, 1'b0, 1'b1, 32'h1000_0005, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h0, 32'h0);
    expect_rd(0, 32'hDEAD_BEEF, 1'b0);
    step();
    chk("idle_hold_p1", bus.Dato_Mem_out[63:32], 32'hDEAD_BEEF);
    chk("idle_novalid_p1", 32'(bus.Dato_valido[1]), 32'h0);

    drive(0, 1'b1, 1'b0, 32'h1000_0001, 32'h11);
    drive(1, 1'b1, 1'b0, 32'h1000_0001, 32'h22);
    step();
    chk("conflict_set", 32'(bus.Conflicto), 32'h1);
    idle_all();
    step();
    chk("conflict_pulse", 32'(bus.Conflicto), 32'h0);

    drive(0, 1'b0, 1'b1, 32'h1000_0001, 32'h0);
    expect_rd(0, 32'h22, 1'b0);
    idle_all();
    drive(0, 1'b0, 1'b1, 32'h1000_0001, 32'h0);
    step();

    idle_all();
    drive(1, 1'b0, 1'b1, 32'h2000_0000, 32'h0);
    expect_rd(1, 32'h20, 1'b1);
    step();
    chk("cnt_one_oor", 32'(bus.Cuenta_err), 32'h1);

    idle_all();
    drive(0, 1'b1, 1'b0, 32'h0FFF_FFFF, 32'h77);
    step();
    chk("oor_write_fr", 32'(bus.Fuera_rango[0]), 32'h1);
    chk("oor_write_novalid", 32'(bus.Dato_valido[0]), 32'h0);
    chk("cnt_two_oor", 32'(bus.Cuenta_err), 32'h2);

    drive(0, 1'b0, 1'b1, 32'h1000_000F, 32'h0);
    drive(1, 1'b0, 1'b1, 32'h1000_0010, 32'h0);
    expect_rd(0, 32'h0, 1'b0);
    expect_rd(1, 32'h20, 1'b1);
    step();
    chk("cnt_edge", 32'(bus.Cuenta_err), 32'h3);

    drive(0, 1'b0, 1'b1, 32'h3000_0000, 32'h0);
    drive(1, 1'b0, 1'b1, 32'h0000_0000, 32'h0);
    expect_rd(0, 32'h20, 1'b1);
    expect_rd(1, 32'h20, 1'b1);
    step();
    chk("cnt_two_ports", 32'(bus.Cuenta_err), 32'h5);

    idle_all();
    drive(0, 1'b0, 1'b0, 32'h1000_0000, 32'h55);
    expect_rd(0, 32'h10, 1'b0);
    step();
    drive(0, 1'b0, 1'b1, 32'h1000_0000, 32'h0);
    expect_rd(0, 32'h10, 1'b0);
    step();

    idle_all();
    for (int i = 0; i < 300; i++) begin
      drive(1, 1'b0, 1'b1, 32'h2000_0000, 32'h0);
      expect_rd(1, 32'h20, 1'b1);
      step();
    end
    chk("cnt_saturated", 32'(bus.Cuenta_err), 32'hFF);
    drive(0, 1'b0, 1'b1, 32'h2000_0001, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h2000_0002, 32'h0);
    expect_rd(0, 32'h20, 1'b1);
    step();
    chk("cnt_stays_sat", 32'(bus.Cuenta_err), 32'hFF);

    idle_all();
    drive(0, 1'b1, 1'b0, 32'h1000_0003, 32'hABCD);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dout0", bus.Dato_Mem_out[31:0], 32'h0);
    chk("midrst_dout1", bus.Dato_Mem_out[63:32], 32'h0);
    chk("midrst_valid", 32'(bus.Dato_valido), 32'h0);
    chk("midrst_fr", 32'(bus.Fuera_rango), 32'h0);
    chk("midrst_conf", 32'(bus.Conflicto), 32'h0);
    chk("midrst_cnt", 32'(bus.Cuenta_err), 32'h0);
    step();
    idle_all();
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b1, 32'h1000_0003, 32'h0);
    drive(1, 1'b0, 1'b1, 32'h1000_0005, 32'h0);
    expect_rd(0, 32'h02, 1'b0);
    expect_rd(1, 32'h0, 1'b0);
    step();
    idle_all();
    step();
    step();

    chk("pending_p0", 32'(expq[0].size()), 32'h0);
    chk("pending_p1", 32'(expq[1].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
